// File: rtl/serial_subtractor_pkg.sv
// rtl/serial_subtractor_pkg.sv - shared types and constants for the bit-serial subtractor
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sub_state_t;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor_cell.sv
// rtl/full_subtractor_cell.sv - one-bit full subtractor built from primitive gates
module full_subtractor_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_diff,
  output logic o_bout
);

  logic w_axb;
  logic w_na;
  logic w_naxb;
  logic w_gen;
  logic w_prop;

  xor u_x0 (w_axb, i_a, i_b);
  xor u_x1 (o_diff, w_axb, i_bin);
  not u_n0 (w_na, i_a);
  not u_n1 (w_naxb, w_axb);
  and u_a0 (w_gen, w_na, i_b);
  and u_a1 (w_prop, w_naxb, i_bin);
  or  u_o0 (o_bout, w_gen, w_prop);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b - bin, LSB first, one bit per clock
// Results and flags update only when the last bit is processed.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_bin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_bout,
  output logic             o_ovf
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_state_next;
  logic             w_load;
  logic             w_last;

  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_borrow;
  logic             r_a_msb;
  logic             r_b_msb;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_ovf;

  logic             w_d;
  logic             w_bout;

  full_subtractor_cell u_cell (
    .i_a    (r_sa[0]),
    .i_b    (r_sb[0]),
    .i_bin  (r_borrow),
    .o_diff (w_d),
    .o_bout (w_bout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_cnt == LAST_BIT) begin
          w_last       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_a_msb  <= 1'b0;
      r_b_msb  <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_sa     <= i_a;
        r_sb     <= i_b;
        r_borrow <= i_bin;
        r_cnt    <= '0;
        r_a_msb  <= i_a[WIDTH-1];
        r_b_msb  <= i_b[WIDTH-1];
      end else if (r_state == RUN) begin
        r_sa     <= r_sa >> 1;
        r_sb     <= r_sb >> 1;
        r_borrow <= w_bout;
        r_res    <= {w_d, r_res[WIDTH-1:1]};
        r_cnt    <= r_cnt + CNT_W'(1);
        // The final difference bit is w_d itself, so the MSB is taken straight from the cell.
        if (w_last) begin
          r_diff <= {w_d, r_res[WIDTH-1:1]};
          r_bout <= w_bout;
          r_ovf  <= (r_a_msb ^ r_b_msb) & (w_d ^ r_a_msb);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = r_done;
  assign o_diff = r_diff;
  assign o_bout = r_bout;
  assign o_ovf  = r_ovf;

endmodule
